// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch-queue constants, FSM states and the queue entry layout.
package fetch_queue_pkg;
    localparam int          FQ_DEPTH    = 4;
    localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FQ_PC_INCR  = 32'd4;
    typedef enum logic {S_BOOT, S_RUN} fq_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: DEPTH-entry {pc,inst} queue with synchronous clear; head output holds the last popped entry when empty.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  fq_entry_t                wdata,
    output fq_entry_t                rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fq_entry_t      mem [DEPTH];
    fq_entry_t      last;
    logic [AW-1:0]  head, tail;
    assign rdata = (count == '0) ? last : mem[head];
    always_ff @(posedge clk)
        if (push && !clear) mem[tail] <= wdata;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            last  <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) begin
                head <= head + 1'b1;
                last <= mem[head];
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage issuing code_mem reads and queueing {pc,inst} for decode; redirect flushes and restarts.
// Optional FETCH_QUEUE_PERF_EN adds saturating perf_flushes / perf_stalls counters.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC,
    parameter logic [31:0] PC_INCR  = FQ_PC_INCR
) (
    input  logic                     clk,
    input  logic                     resetn,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst_out,
    output logic [31:0]              inst_pc,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   queue_count
`ifdef FETCH_QUEUE_PERF_EN
   ,output logic [31:0]              perf_flushes,
    output logic [31:0]              perf_stalls
`endif
);
    fq_state_t   state;
    logic [31:0] fetch_pc, tag_pc;
    logic        inflight, drop, push, pop;
    fq_entry_t   head;
    // Credit check counts the outstanding read so its response always has a slot.
    assign imem_req   = (state == S_RUN) && !redirect && (32'(queue_count) + 32'(inflight) < DEPTH);
    assign imem_addr  = fetch_pc;
    assign push       = inflight && !drop && !redirect;
    assign inst_valid = (queue_count != '0) && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign inst_out   = head.inst;
    assign inst_pc    = head.pc;
    fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clear  (redirect),
        .push   (push),
        .pop    (pop),
        .wdata  ('{pc: tag_pc, inst: imem_rdata}),
        .rdata  (head),
        .count  (queue_count)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state    <= S_RUN;
            inflight <= imem_req;
            drop     <= redirect && inflight;
            if (redirect)
                fetch_pc <= redirect_pc & ~32'h3;
            else if (imem_req) begin
                fetch_pc <= fetch_pc + PC_INCR;
                tag_pc   <= fetch_pc;
            end
        end
    end
`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_flushes <= '0;
            perf_stalls  <= '0;
        end else begin
            if (redirect && perf_flushes != '1) perf_flushes <= perf_flushes + 1'b1;
            if (inst_valid && !inst_ready && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a 1-cycle-latency code_mem model.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_out, inst_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [2:0]  queue_count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_flushes, perf_stalls;
`endif
    int n_cmp = 0;
    int n_err = 0;

    fetch_queue dut (
        .clk         (clk),
        .resetn      (resetn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .queue_count (queue_count)
`ifdef FETCH_QUEUE_PERF_EN
       ,.perf_flushes(perf_flushes),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0001;
    endfunction

    always @(posedge clk)
        if (imem_req) imem_rdata <= word_at(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3;
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_count", 32'(queue_count), 0);
        check("rst_inst", inst_out, 0);
        check("rst_pc", inst_pc, 0);
        resetn = 1'b1;
        #1 check("boot_req", 32'(imem_req), 0);
        cyc(); #1;
        check("c1_req", 32'(imem_req), 1);
        check("c1_addr", imem_addr, 32'h0);
        cyc(); #1;
        check("c2_valid", 32'(inst_valid), 0);
        check("c2_addr", imem_addr, 32'h4);
        cyc(); #1;
        check("c3_valid", 32'(inst_valid), 1);
        check("c3_pc", inst_pc, 32'h0);
        check("c3_inst", inst_out, word_at(32'h0));
        cyc(); #1;
        check("c4_pc", inst_pc, 32'h4);
        cyc(); #1;
        check("c5_pc", inst_pc, 32'h8);
        check("c5_inst", inst_out, word_at(32'h8));
        for (int i = 0; i < 10; i++) begin
            cyc();
            inst_ready = 1'b0;
        end
        #1;
        check("stall_count", 32'(queue_count), 4);
        check("stall_req", 32'(imem_req), 0);
        check("stall_pc", inst_pc, 32'hC);
        for (int i = 0; i < 6; i++) begin
            cyc();
            inst_ready = 1'b1;
            #1;
            check("drain_valid", 32'(inst_valid), 1);
            check("drain_pc", inst_pc, 32'hC + 32'(4 * i));
            check("drain_inst", inst_out, word_at(32'hC + 32'(4 * i)));
        end
        cyc();
        inst_ready = 1'b0;
        cyc();
        inst_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("rd_count_before", 32'(queue_count), 3);
        check("rd_req", 32'(imem_req), 0);
        check("rd_valid", 32'(inst_valid), 0);
        cyc();
        redirect = 1'b0;
        #1;
        check("rd1_count", 32'(queue_count), 0);
        check("rd1_valid", 32'(inst_valid), 0);
        check("rd1_req", 32'(imem_req), 1);
        check("rd1_addr", imem_addr, 32'h40);
        cyc(); #1;
        check("rd2_valid", 32'(inst_valid), 0);
        cyc(); #1;
        check("rd3_valid", 32'(inst_valid), 1);
        check("rd3_pc", inst_pc, 32'h40);
        check("rd3_inst", inst_out, word_at(32'h40));
        cyc(); #1;
        check("rd4_pc", inst_pc, 32'h44);
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        #1 check("b2b0_req", 32'(imem_req), 0);
        cyc();
        redirect_pc = 32'h43;
        #1;
        check("b2b1_req", 32'(imem_req), 0);
        check("b2b1_valid", 32'(inst_valid), 0);
        cyc();
        redirect = 1'b0;
        #1;
        check("b2b2_req", 32'(imem_req), 1);
        check("b2b2_addr", imem_addr, 32'h40);
        cyc();
        cyc(); #1;
        check("b2b4_valid", 32'(inst_valid), 1);
        check("b2b4_pc", inst_pc, 32'h40);
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        #1 check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc(); #1;
        check("wrap_req", 32'(imem_req), 1);
        check("wrap_addr1", imem_addr, 32'h0);
        cyc(); #1;
        check("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
        cyc(); #1;
        check("wrap_pc1", inst_pc, 32'h0);
        check("wrap_inst1", inst_out, word_at(32'h0));
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(inst_valid), 0);
        check("mid_rst_count", 32'(queue_count), 0);
        check("mid_rst_req", 32'(imem_req), 0);
        check("mid_rst_pc", inst_pc, 0);
        cyc();
        resetn = 1'b1;
        #1 check("rb0_req", 32'(imem_req), 0);
        cyc(); #1;
        check("rb1_req", 32'(imem_req), 1);
        check("rb1_addr", imem_addr, 32'h0);
        cyc();
        cyc(); #1;
        check("rb3_valid", 32'(inst_valid), 1);
        check("rb3_pc", inst_pc, 32'h0);
        inst_ready = 1'b0;
        repeat (6) cyc();
        #1 check("rb9_valid", 32'(inst_valid), 1);
        cyc();
        inst_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        cyc();
        cyc();
        redirect = 1'b0;
        #1;
        check("post_perf_count", 32'(queue_count), 0);
`ifdef FETCH_QUEUE_PERF_EN
        check("perf_flushes", perf_flushes, 32'd3);
        check("perf_stalls", perf_stalls, 32'd7);
`endif
        resetn = 1'b0;
        #1;
        check("final_rst_valid", 32'(inst_valid), 0);
`ifdef FETCH_QUEUE_PERF_EN
        check("perf_flushes_rst", perf_flushes, 32'd0);
        check("perf_stalls_rst", perf_stalls, 32'd0);
`endif
        resetn = 1'b1;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
